// File: rtl/arm_pkg.sv
// Shared types for the ARM32 decode stage: field enums, the decoded bundle and condition evaluation.
package arm_pkg;

    // Widest PC the bundle can carry; the stage uses only the low PC_W bits.
    localparam int PC_MAX_W = 64;

    typedef enum logic [1:0] {
        T_DP    = 2'b00,
        T_LS    = 2'b01,
        T_BR    = 2'b10,
        T_OTHER = 2'b11
    } instr_type_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [3:0] {
        C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
        C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
    } cond_e;

    typedef struct packed {
        cond_e                 cond;
        instr_type_e           types;
        logic [3:0]            opcode;
        logic [3:0]            rn;
        logic [3:0]            rd;
        logic [3:0]            rs;
        logic [3:0]            rm;
        logic                  imm_f;
        logic                  setf;
        shift_e                shift_op;
        logic [31:0]           op2;
        logic [PC_MAX_W-1:0]   br_tgt;
    } decoded_t;

    function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            C_EQ:    cond_pass = z;
            C_NE:    cond_pass = ~z;
            C_CS:    cond_pass = c;
            C_CC:    cond_pass = ~c;
            C_MI:    cond_pass = n;
            C_PL:    cond_pass = ~n;
            C_VS:    cond_pass = v;
            C_VC:    cond_pass = ~v;
            C_HI:    cond_pass = c & ~z;
            C_LS:    cond_pass = ~c | z;
            C_GE:    cond_pass = (n == v);
            C_LT:    cond_pass = (n != v);
            C_GT:    cond_pass = ~z & (n == v);
            C_LE:    cond_pass = z | (n != v);
            C_AL:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/idecode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface idecode_stage_if #(parameter int PC_W = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_ir;
    logic [PC_W-1:0]  in_pc;
    logic [3:0]       flags_nzcv;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_cond;
    logic [1:0]       out_types;
    logic [3:0]       out_opcode;
    logic [3:0]       out_rn;
    logic [3:0]       out_rd;
    logic [3:0]       out_rs;
    logic [3:0]       out_rm;
    logic             out_imm_f;
    logic             out_setf;
    logic [1:0]       out_shift_op;
    logic [31:0]      out_op2;
    logic [PC_W-1:0]  out_br_tgt;
    logic             out_exec;

    modport master (
        output flush, in_valid, in_ir, in_pc, flags_nzcv, out_ready,
        input  in_ready, out_valid, out_cond, out_types, out_opcode, out_rn, out_rd,
               out_rs, out_rm, out_imm_f, out_setf, out_shift_op, out_op2, out_br_tgt, out_exec
    );

    modport slave (
        input  flush, in_valid, in_ir, in_pc, flags_nzcv, out_ready,
        output in_ready, out_valid, out_cond, out_types, out_opcode, out_rn, out_rd,
               out_rs, out_rm, out_imm_f, out_setf, out_shift_op, out_op2, out_br_tgt, out_exec
    );
endinterface

// File: rtl/idecode_comb.sv
// Pure combinational ARM32 field split: rotated-immediate expansion and branch-target arithmetic.
module idecode_comb
    import arm_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int PC_AHEAD = 8
) (
    input  logic [31:0]     ir,
    input  logic [PC_W-1:0] pc,
    output decoded_t        dec
);

    logic [4:0]              rot_amt;
    logic [63:0]             imm_dbl;
    logic [31:0]             imm_rot;
    logic signed [25:0]      br_off;
    logic signed [PC_W-1:0]  br_off_x;
    logic [PC_W-1:0]         tgt;

    // Rotating a doubled copy right leaves the 32-bit rotate-right in the low word.
    assign rot_amt  = {ir[11:8], 1'b0};
    assign imm_dbl  = {24'd0, ir[7:0], 24'd0, ir[7:0]};
    assign imm_rot  = 32'(imm_dbl >> rot_amt);

    assign br_off   = signed'({ir[23:0], 2'b00});
    assign br_off_x = PC_W'(br_off);
    assign tgt      = pc + PC_W'(PC_AHEAD) + $unsigned(br_off_x);

    always_comb begin
        dec          = '0;
        dec.cond     = cond_e'(ir[31:28]);
        dec.types    = instr_type_e'(ir[27:26]);
        dec.opcode   = ir[24:21];
        dec.rn       = ir[19:16];
        dec.rd       = ir[15:12];
        dec.rs       = ir[11:8];
        dec.rm       = ir[3:0];
        dec.imm_f    = ir[25];
        dec.setf     = ir[20];
        dec.shift_op = shift_e'(ir[6:5]);
        case (dec.types)
            T_DP:    if (ir[25]) dec.op2 = imm_rot;
            T_LS:    dec.op2 = {20'd0, ir[11:0]};
            T_BR:    dec.br_tgt = PC_MAX_W'(tgt);
            default: ;
        endcase
    end

endmodule

// File: rtl/idecode_stage.sv
// Registered decode stage: one decoder feeding a main slot plus an optional skid slot, FIFO ordered.
module idecode_stage
    import arm_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter bit SKID_EN  = 1'b1,
    parameter int PC_AHEAD = 8
) (
    input  logic            clk,
    input  logic            rst,
    idecode_stage_if.slave  bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0] state, state_nx;
    decoded_t   dec_p0, main_p1, skid_p1;
    logic       rdy_p1, vld_p1, in_rdy, in_fire, out_fire;
    logic       ld_main, ld_skid, main_from_skid;
    logic       br_unused;

    idecode_comb #(.PC_W(PC_W), .PC_AHEAD(PC_AHEAD)) u_comb (
        .ir  (bus.in_ir),
        .pc  (bus.in_pc),
        .dec (dec_p0)
    );

    assign vld_p1   = (state != ST_EMPTY);
    assign in_rdy   = SKID_EN ? rdy_p1 : (bus.out_ready | ~vld_p1);
    assign in_fire  = bus.in_valid & in_rdy;
    assign out_fire = vld_p1 & bus.out_ready;

    always_comb begin
        state_nx       = state;
        ld_main        = 1'b0;
        ld_skid        = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) begin
                    state_nx = ST_ONE;
                    ld_main  = 1'b1;
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main = 1'b1;
                    end else if (in_fire) begin
                        state_nx = ST_TWO;
                        ld_skid  = 1'b1;
                    end else if (out_fire) begin
                        state_nx = ST_EMPTY;
                    end
                end
                ST_TWO: if (out_fire) begin
                    state_nx       = ST_ONE;
                    ld_main        = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // ---- p0 -> p1 register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            rdy_p1  <= 1'b1;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            state  <= state_nx;
            rdy_p1 <= (state_nx != ST_TWO);
            if (ld_main) main_p1 <= main_from_skid ? skid_p1 : dec_p0;
            if (ld_skid) skid_p1 <= dec_p0;
        end
    end

    // Bundle carries a wide target; bits above PC_W are always zero.
    assign br_unused = |(main_p1.br_tgt >> PC_W);

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = vld_p1;
    assign bus.out_cond     = main_p1.cond;
    assign bus.out_types    = main_p1.types;
    assign bus.out_opcode   = main_p1.opcode;
    assign bus.out_rn       = main_p1.rn;
    assign bus.out_rd       = main_p1.rd;
    assign bus.out_rs       = main_p1.rs;
    assign bus.out_rm       = main_p1.rm;
    assign bus.out_imm_f    = main_p1.imm_f;
    assign bus.out_setf     = main_p1.setf;
    assign bus.out_shift_op = main_p1.shift_op;
    assign bus.out_op2      = main_p1.op2;
    assign bus.out_br_tgt   = main_p1.br_tgt[PC_W-1:0];
    assign bus.out_exec     = cond_pass(main_p1.cond, bus.flags_nzcv);

endmodule

// File: tb/tb_idecode_stage.sv
// Scoreboard bench for idecode_stage: skid (A) and non-skid (B) instances share one driver, selected by sel.
module tb_idecode_stage;
    import arm_pkg::*;

    localparam int PC_W = 32;

    typedef struct packed {
        decoded_t d;
        logic     exec;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sel = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_ir = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic [3:0]      flags = '0;

    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    idecode_stage_if #(.PC_W(PC_W)) bus_a ();
    idecode_stage_if #(.PC_W(PC_W)) bus_b ();

    idecode_stage #(.PC_W(PC_W), .SKID_EN(1'b1), .PC_AHEAD(8)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    idecode_stage #(.PC_W(PC_W), .SKID_EN(1'b0), .PC_AHEAD(8)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    assign bus_a.in_valid   = in_valid & ~sel;
    assign bus_b.in_valid   = in_valid & sel;
    assign bus_a.flush      = flush & ~sel;
    assign bus_b.flush      = flush & sel;
    assign bus_a.in_ir      = in_ir;
    assign bus_b.in_ir      = in_ir;
    assign bus_a.in_pc      = in_pc;
    assign bus_b.in_pc      = in_pc;
    assign bus_a.flags_nzcv = flags;
    assign bus_b.flags_nzcv = flags;
    assign bus_a.out_ready  = out_ready;
    assign bus_b.out_ready  = out_ready;

    function automatic decoded_t mk(input logic [3:0] c, input logic [1:0] t,
                                    input logic [3:0] op, rn, rd, rs, rm,
                                    input logic imf, sf, input logic [1:0] sh,
                                    input logic [31:0] op2, input logic [PC_W-1:0] br);
        decoded_t d;
        d          = '0;
        d.cond     = cond_e'(c);
        d.types    = instr_type_e'(t);
        d.opcode   = op;
        d.rn       = rn;
        d.rd       = rd;
        d.rs       = rs;
        d.rm       = rm;
        d.imm_f    = imf;
        d.setf     = sf;
        d.shift_op = shift_e'(sh);
        d.op2      = op2;
        d.br_tgt   = PC_MAX_W'(br);
        return d;
    endfunction

    function automatic exp_t mkx(input decoded_t d, input logic x);
        exp_t e;
        e.d    = d;
        e.exec = x;
        return e;
    endfunction

    decoded_t act_a, act_b, act;
    logic     cur_vld, cur_rdy, cur_exec;

    assign act_a = mk(bus_a.out_cond, bus_a.out_types, bus_a.out_opcode, bus_a.out_rn, bus_a.out_rd,
                      bus_a.out_rs, bus_a.out_rm, bus_a.out_imm_f, bus_a.out_setf,
                      bus_a.out_shift_op, bus_a.out_op2, bus_a.out_br_tgt);
    assign act_b = mk(bus_b.out_cond, bus_b.out_types, bus_b.out_opcode, bus_b.out_rn, bus_b.out_rd,
                      bus_b.out_rs, bus_b.out_rm, bus_b.out_imm_f, bus_b.out_setf,
                      bus_b.out_shift_op, bus_b.out_op2, bus_b.out_br_tgt);
    assign act      = sel ? act_b : act_a;
    assign cur_vld  = sel ? bus_b.out_valid : bus_a.out_valid;
    assign cur_rdy  = sel ? bus_b.in_ready : bus_a.in_ready;
    assign cur_exec = sel ? bus_b.out_exec : bus_a.out_exec;

    task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, a, e);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected bundle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && cur_vld && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat got=%0h exp=none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("bundle", 160'(act), 160'(e.d));
                    chk("exec", 160'(cur_exec), 160'(e.exec));
                end
            end
        end
    end

    task automatic send(input logic [31:0] ir, input logic [PC_W-1:0] pc, input exp_t e, input bit push);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_ir    = ir;
        in_pc    = pc;
        @(negedge clk);
        while (!cur_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!cur_rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=in_ready_low exp=in_ready_high ir=%h", ir);
        end else begin
            accepted++;
            if (push) exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_left", 160'(exp_q.size()), 160'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic bp_run(input int exp_acc);
        accepted  = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'hE0800000 | (32'(i) << 16) | (32'(i + 1) << 12) | 32'(i + 2), 32'(i * 4),
                         mkx(mk(4'hE, 2'b00, 4'h4, 4'(i), 4'(i + 1), 4'h0, 4'(i + 2),
                                1'b0, 1'b0, 2'b00, 32'h0, '0), 1'b1), 1'b1);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (!cur_rdy && !seen) begin
                        seen = 1'b1;
                        chk("stall_accepted", 160'(accepted), 160'(exp_acc));
                    end
                end
                chk("stall_seen", 160'(seen), 160'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld_a", 160'(bus_a.out_valid), 160'(0));
        chk("rst_fields_a", 160'(act_a), 160'(0));
        chk("rst_vld_b", 160'(bus_b.out_valid), 160'(0));
        chk("rst_fields_b", 160'(act_b), 160'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy_a", 160'(bus_a.in_ready), 160'(1));
        chk("rst_rdy_b", 160'(bus_b.in_ready), 160'(1));
        @(posedge clk);
        #1;

        // Directed decode vectors on the skid instance
        sel       = 1'b0;
        out_ready = 1'b1;
        flags     = 4'b0000;
        send(32'hE3A014FF, 32'h0, mkx(mk(4'hE, 2'b00, 4'hD, 4'h0, 4'h1, 4'h4, 4'hF, 1'b1, 1'b0, 2'b11,
                                         32'hFF000000, 32'h0), 1'b1), 1'b1);
        send(32'hE3A00FFF, 32'h0, mkx(mk(4'hE, 2'b00, 4'hD, 4'h0, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 2'b11,
                                         32'h000003FC, 32'h0), 1'b1), 1'b1);
        send(32'hE3A000AB, 32'h0, mkx(mk(4'hE, 2'b00, 4'hD, 4'h0, 4'h0, 4'h0, 4'hB, 1'b1, 1'b0, 2'b01,
                                         32'h000000AB, 32'h0), 1'b1), 1'b1);
        send(32'hE0812003, 32'h0, mkx(mk(4'hE, 2'b00, 4'h4, 4'h1, 4'h2, 4'h0, 4'h3, 1'b0, 1'b0, 2'b00,
                                         32'h0, 32'h0), 1'b1), 1'b1);
        send(32'hE5912004, 32'h0, mkx(mk(4'hE, 2'b01, 4'hC, 4'h1, 4'h2, 4'h0, 4'h4, 1'b0, 1'b1, 2'b00,
                                         32'h00000004, 32'h0), 1'b1), 1'b1);
        send(32'hEAFFFFFE, 32'h100, mkx(mk(4'hE, 2'b10, 4'h7, 4'hF, 4'hF, 4'hF, 4'hE, 1'b1, 1'b1, 2'b11,
                                           32'h0, 32'h100), 1'b1), 1'b1);
        send(32'hEA000000, 32'hFFFFFFF8, mkx(mk(4'hE, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0,
                                                2'b00, 32'h0, 32'h0), 1'b1), 1'b1);
        send(32'hEE012F10, 32'h0, mkx(mk(4'hE, 2'b11, 4'h0, 4'h1, 4'h2, 4'hF, 4'h0, 1'b1, 1'b0, 2'b00,
                                         32'h0, 32'h0), 1'b1), 1'b1);
        drain();

        // Condition codes against live flags
        send(32'h0A000003, 32'h200, mkx(mk(4'h0, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 2'b00,
                                           32'h0, 32'h214), 1'b0), 1'b1);
        drain();
        flags = 4'b0100;
        send(32'h0A000003, 32'h200, mkx(mk(4'h0, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 2'b00,
                                           32'h0, 32'h214), 1'b1), 1'b1);
        drain();
        flags = 4'b0010;
        send(32'h8A000003, 32'h200, mkx(mk(4'h8, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 2'b00,
                                           32'h0, 32'h214), 1'b1), 1'b1);
        drain();
        flags = 4'b1000;
        send(32'hCA000003, 32'h200, mkx(mk(4'hC, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 2'b00,
                                           32'h0, 32'h214), 1'b0), 1'b1);
        send(32'hDA000003, 32'h200, mkx(mk(4'hD, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 2'b00,
                                           32'h0, 32'h214), 1'b1), 1'b1);
        send(32'hFA000003, 32'h200, mkx(mk(4'hF, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 2'b00,
                                           32'h0, 32'h214), 1'b0), 1'b1);
        drain();
        flags = 4'b0000;

        // Backpressure: skid stalls after two, plain register after one
        sel = 1'b0;
        bp_run(2);
        sel = 1'b1;
        bp_run(1);

        // Flush drops two held beats and the beat offered in the flush cycle
        sel       = 1'b0;
        out_ready = 1'b0;
        send(32'hE3A014FF, 32'h0, mkx('0, 1'b0), 1'b0);
        send(32'hE5912004, 32'h4, mkx('0, 1'b0), 1'b0);
        in_valid = 1'b1;
        in_ir    = 32'hEAFFFFFE;
        in_pc    = 32'h8;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_vld", 160'(cur_vld), 160'(0));
        chk("flush_rdy", 160'(cur_rdy), 160'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        send(32'hE0812003, 32'h0, mkx(mk(4'hE, 2'b00, 4'h4, 4'h1, 4'h2, 4'h0, 4'h3, 1'b0, 1'b0, 2'b00,
                                         32'h0, 32'h0), 1'b1), 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
